dmem_responder: RTL and testbench

Data-memory responder for the CPU's load/store port: accepts one word-wide read or write request at a time, inserts a programmable number of wait states, commits the access to internal word storage and returns a one-cycle acknowledge with read data. It sits on the target side of the CPU data-memory interface, in place of a zero-latency RAM, so the core's stall/handshake path can be built and exercised against a realistic slave.

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data-memory slave for the CPU load/store port.
// Accepts one request at a time, waits WAIT_CYCLES states, commits the access
// to internal storage, then pulses ack for one cycle with read data.
// Optional build macro: DMEM_RESP_ERR_EN adds the err output and faults
// misaligned or out-of-range accesses.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata
`ifdef DMEM_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            cnt;
  logic                  lat_we;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [31:0]           mem [DEPTH];
  logic                  accept;
  logic                  exec;
  logic                  fault;
  logic [DEPTH_LOG2-1:0] idx;

  // A new request is taken from IDLE or straight out of RESP (back-to-back)
  assign accept = req && ((state == S_IDLE) || (state == S_RESP));
  assign exec   = (state == S_WAIT) && (cnt == 4'd0);
  assign idx    = lat_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_RESP_ERR_EN
  logic err_q;

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
  endfunction

  assign fault = addr_fault(lat_addr);
`else
  // Byte-offset and high address bits are don't-care: addresses alias
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lat_addr[1:0], lat_addr[31:DEPTH_LOG2+2]};
  assign fault = 1'b0;
`endif

  // State register and wait-state counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 4'(WAIT_CYCLES);
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_WAIT;
      S_WAIT:  if (exec) state_nxt = S_RESP;
      S_RESP:  state_nxt = accept ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state == S_WAIT) || (state == S_RESP);
    ack  = (state == S_RESP);
`ifdef DMEM_RESP_ERR_EN
    err  = (state == S_RESP) && err_q;
`endif
  end

  // Request latch: the held copy is what executes, regardless of bus changes
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= we;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end
  end

  // Word storage write port; contents survive reset
  always_ff @(posedge clk) begin
    if (exec && lat_we && !fault) begin
      mem[idx] <= lat_wdata;
    end
  end

  // Read data register, updated only by an executing read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= 32'd0;
    end else if (exec && !lat_we) begin
      rdata <= fault ? 32'd0 : mem[idx];
    end
  end

`ifdef DMEM_RESP_ERR_EN
  // Fault flag captured at execute, shown only alongside ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (exec) begin
      err_q <= fault;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (1 and 0 wait states) share the
// request bus; sel steers req. Expected acks are queued when a request is
// accepted and checked (cycle, data, err) when ack appears.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int WA = 1;
  localparam int WB = 0;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic        sel   = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        req_a, req_b;
  logic        busy_a, ack_a, busy_b, ack_b;
  logic [31:0] rdata_a, rdata_b;
  logic        err_a, err_b;

  int   cyc        = 0;
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   extra_acks = 0;
  int   busy_drops = 0;
  int   err_idle   = 0;
  logic watch      = 1'b0;

  typedef struct {
    logic        unit;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } sb_t;

  sb_t sbq[$];

  assign req_a = req & ~sel;
  assign req_b = req & sel;

`ifndef DMEM_RESP_ERR_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(WA)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_a), .ack(ack_a), .rdata(rdata_a)
`ifdef DMEM_RESP_ERR_EN
    , .err(err_a)
`endif
  );

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(WB)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_b), .ack(ack_b), .rdata(rdata_b)
`ifdef DMEM_RESP_ERR_EN
    , .err(err_b)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic score(input logic unit, input logic [31:0] rd, input logic e);
    sb_t x;
    if (sbq.size() == 0) begin
      extra_acks++;
      return;
    end
    x = sbq.pop_front();
    chk("ack_unit", 32'(unit), 32'(x.unit));
    chk("ack_cycle", cyc, x.cyc);
    if (!x.we) chk("rdata", rd, x.rdata);
    chk("err_at_ack", 32'(e), 32'(x.err));
  endtask

  // Scoreboard consumer and idle-time monitors
  always @(negedge clk) begin
    if (!reset) begin
      if (ack_a) score(1'b0, rdata_a, err_a);
      if (ack_b) score(1'b1, rdata_b, err_b);
      if (watch && !busy_b) busy_drops++;
      if (!ack_a && err_a) err_idle++;
      if (!ack_b && err_b) err_idle++;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input logic hold);
    sb_t  x;
    int   guard = 0;
    logic bs, ak;
    @(negedge clk);
    bs = sel ? busy_b : busy_a;
    ak = sel ? ack_b : ack_a;
    while (bs && !ak && guard < 50) begin
      @(negedge clk);
      guard++;
      bs = sel ? busy_b : busy_a;
      ak = sel ? ack_b : ack_a;
    end
    if (guard >= 50) chk("issue_timeout", guard, 0);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    x.unit  = sel;
    x.we    = w;
    x.rdata = exp_rd;
    x.err   = exp_err;
    x.cyc   = cyc + 1 + (sel ? WB : WA);
    sbq.push_back(x);
    chk("busy_after_req", 32'(sel ? busy_b : busy_a), 32'd1);
    if (!hold) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() != 0 && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    reset = 1'b0;

    // Write then read back, timing checked against the scoreboard
    issue(1'b1, 32'h10, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    issue(1'b0, 32'h10, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
    drain();

    // Request pulsed during WAIT must be ignored
    issue(1'b1, 32'h30, 32'hAAAA_0001, 32'd0, 1'b0, 1'b0);
    issue(1'b1, 32'h34, 32'hBBBB_0002, 32'd0, 1'b0, 1'b0);
    issue(1'b0, 32'h30, 32'd0, 32'hAAAA_0001, 1'b0, 1'b0);
    req = 1'b1; we = 1'b1; addr = 32'h34; wdata = 32'hDEAD_0000;
    @(negedge clk);
    req = 1'b0;
    drain();
    issue(1'b0, 32'h34, 32'd0, 32'hBBBB_0002, 1'b0, 1'b0);
    drain();

    // Reset during WAIT abandons the write
    issue(1'b1, 32'h20, 32'h0000_1111, 32'd0, 1'b0, 1'b0);
    issue(1'b0, 32'h30, 32'd0, 32'hAAAA_0001, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0000_2222;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("wait_rst_busy", 32'(busy_a), 32'd0);
    chk("wait_rst_ack", 32'(ack_a), 32'd0);
    chk("wait_rst_rdata", rdata_a, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 32'h20, 32'd0, 32'h0000_1111, 1'b0, 1'b0);
    drain();

`ifndef DMEM_RESP_ERR_EN
    // Address aliasing and ignored byte offset
    issue(1'b1, 32'h100, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    issue(1'b0, 32'h0, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0);
    issue(1'b0, 32'h2, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0);
`else
    // Out-of-range write faults and leaves word 0; misaligned read faults
    issue(1'b1, 32'h0, 32'h0000_0055, 32'd0, 1'b0, 1'b0);
    issue(1'b1, 32'h100, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0);
    issue(1'b0, 32'h0, 32'd0, 32'h0000_0055, 1'b0, 1'b0);
    issue(1'b0, 32'h2, 32'd0, 32'd0, 1'b1, 1'b0);
`endif
    drain();

    // Zero wait states: preload, then back-to-back reads with req held
    @(negedge clk);
    sel = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(1'b1, 32'(i * 4), 32'hB0B0_0000 + 32'(i), 32'd0, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'(i * 4), 32'd0, 32'hB0B0_0000 + 32'(i), 1'b0, (i < 3));
      if (i == 0) watch = 1'b1;
    end
    drain();
    watch = 1'b0;

    repeat (4) @(negedge clk);
    chk("extra_acks", extra_acks, 0);
    chk("busy_drops", busy_drops, 0);
    chk("err_idle", err_idle, 0);
    chk("sb_left", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
